// File: rtl/slave_rx_port_p_if.sv
// Bus bundle between the interconnect (master side) and the serial slave receive port.
interface slave_rx_port_p_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int BURST_WIDTH = 12
);
  logic                   rx_addr;
  logic                   rx_data;
  logic                   master_valid;
  logic                   master_ready;
  logic                   write_en;
  logic                   read_en;
  logic [BURST_WIDTH-1:0] burst_len;
  logic                   slave_ready;
  logic [ADDR_WIDTH-1:0]  addr_out;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   wr_req;
  logic                   rd_req;
  logic [BURST_WIDTH-1:0] beat_count;
  logic                   rx_done;
  logic                   err;

  modport master (
    output rx_addr, rx_data, master_valid, master_ready, write_en, read_en, burst_len,
    input  slave_ready, addr_out, data_out, wr_req, rd_req, beat_count, rx_done, err
  );

  modport slave (
    input  rx_addr, rx_data, master_valid, master_ready, write_en, read_en, burst_len,
    output slave_ready, addr_out, data_out, wr_req, rd_req, beat_count, rx_done, err
  );
endinterface

// File: rtl/slave_rx_port_p.sv
// Serial LSB-first receive port: request N+1 edges after handshake (N = RX length), master_ready stalls read bursts.
// Define SLAVE_RX_PARITY_EN to append an even-parity bit to every serial word (mismatch turns the request into err).
module slave_rx_port_p #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int BURST_WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  slave_rx_port_p_if.slave bus
);

`ifdef SLAVE_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 2);

  localparam logic [CW-1:0] A_LEN   = CW'(ADDR_WIDTH);
  localparam logic [CW-1:0] D_LEN   = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] RD_LAST = CW'(ADDR_WIDTH + PAR - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(MAXW + PAR - 1);
  localparam logic [CW-1:0] WD_LAST = CW'(DATA_WIDTH + PAR - 1);

  typedef enum logic [2:0] {
    IDLE, RX, ISSUE, WR_WAIT, WR_DATA, RD_BURST, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   is_wr_q, is_wr_d;
  logic [BURST_WIDTH-1:0] blen_q, blen_d;
  logic [BURST_WIDTH-1:0] beat_q, beat_d;
  logic [BURST_WIDTH-1:0] beat_inc;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   slave_ready_q, slave_ready_d;
  logic                   wr_req_q, wr_req_d;
  logic                   rd_req_q, rd_req_d;
  logic                   rx_done_q, rx_done_d;
  logic                   err_q, err_d;
  logic                   par_err_q, par_err_d;

  logic handshake;
  logic mode_ok;
  logic rx_last;
  logic wd_last;
  logic last_beat;

  assign handshake = bus.master_valid & slave_ready_q;
  assign mode_ok   = bus.write_en ^ bus.read_en;
  assign rx_last   = (cnt_q == (is_wr_q ? WR_LAST : RD_LAST));
  assign wd_last   = (cnt_q == WD_LAST);
  assign last_beat = (beat_q == blen_q);
  assign beat_inc  = beat_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (handshake && mode_ok) state_d = RX;
      RX:       if (rx_last) state_d = ISSUE;
      ISSUE: begin
        if (last_beat)    state_d = DONE;
        else if (is_wr_q) state_d = WR_WAIT;
        else              state_d = RD_BURST;
      end
      WR_WAIT:  if (handshake) state_d = WR_DATA;
      WR_DATA:  if (wd_last) state_d = ISSUE;
      RD_BURST: if (bus.master_ready && (beat_inc == blen_q)) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    is_wr_d       = is_wr_q;
    blen_d        = blen_q;
    beat_d        = beat_q;
    addr_d        = addr_q;
    data_d        = data_q;
    par_err_d     = par_err_q;
    wr_req_d      = 1'b0;
    rd_req_d      = 1'b0;
    rx_done_d     = 1'b0;
    err_d         = 1'b0;
    slave_ready_d = (state_d == IDLE) || (state_d == WR_WAIT);

    case (state_q)
      IDLE: begin
        if (handshake && mode_ok) begin
          is_wr_d   = bus.write_en;
          blen_d    = bus.burst_len;
          beat_d    = '0;
          cnt_d     = '0;
          par_err_d = 1'b0;
        end else if (handshake && bus.write_en && bus.read_en) begin
          err_d = 1'b1;
        end
      end
      RX: begin
        cnt_d = rx_last ? '0 : cnt_q + 1'b1;
        if (cnt_q < A_LEN) addr_d = {bus.rx_addr, addr_q[ADDR_WIDTH-1:1]};
        if (is_wr_q && (cnt_q < D_LEN)) data_d = {bus.rx_data, data_q[DATA_WIDTH-1:1]};
        // Parity bits trail each word's MSB; the word is complete in its register by then.
        if (PAR != 0) begin
          if (cnt_q == A_LEN) par_err_d = par_err_d | (bus.rx_addr ^ (^addr_q));
          if (is_wr_q && (cnt_q == D_LEN)) par_err_d = par_err_d | (bus.rx_data ^ (^data_q));
        end
      end
      ISSUE: begin
        cnt_d     = '0;
        par_err_d = 1'b0;
        if (par_err_q)    err_d    = 1'b1;
        else if (is_wr_q) wr_req_d = 1'b1;
        else              rd_req_d = 1'b1;
      end
      WR_WAIT: begin
        if (handshake) begin
          addr_d = addr_q + 1'b1;
          beat_d = beat_inc;
          cnt_d  = '0;
        end
      end
      WR_DATA: begin
        cnt_d = wd_last ? '0 : cnt_q + 1'b1;
        if (cnt_q < D_LEN) data_d = {bus.rx_data, data_q[DATA_WIDTH-1:1]};
        if ((PAR != 0) && (cnt_q == D_LEN)) par_err_d = bus.rx_data ^ (^data_q);
      end
      RD_BURST: begin
        if (bus.master_ready) begin
          addr_d   = addr_q + 1'b1;
          beat_d   = beat_inc;
          rd_req_d = 1'b1;
        end
      end
      DONE:    rx_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      is_wr_q       <= 1'b0;
      blen_q        <= '0;
      beat_q        <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      par_err_q     <= 1'b0;
      slave_ready_q <= 1'b0;
      wr_req_q      <= 1'b0;
      rd_req_q      <= 1'b0;
      rx_done_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      is_wr_q       <= is_wr_d;
      blen_q        <= blen_d;
      beat_q        <= beat_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      par_err_q     <= par_err_d;
      slave_ready_q <= slave_ready_d;
      wr_req_q      <= wr_req_d;
      rd_req_q      <= rd_req_d;
      rx_done_q     <= rx_done_d;
      err_q         <= err_d;
    end
  end

  assign bus.slave_ready = slave_ready_q;
  assign bus.addr_out    = addr_q;
  assign bus.data_out    = data_q;
  assign bus.wr_req      = wr_req_q;
  assign bus.rd_req      = rd_req_q;
  assign bus.beat_count  = beat_q;
  assign bus.rx_done     = rx_done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_slave_rx_port_p.sv
// Scoreboard bench for slave_rx_port_p: drives serial transactions, a monitor pops expected events per strobe.
module tb_slave_rx_port_p;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int BW = 12;
`ifdef SLAVE_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int MAXW = (AW > DW) ? AW : DW;

  localparam int EV_WR   = 0;
  localparam int EV_RD   = 1;
  localparam int EV_ERR  = 2;
  localparam int EV_DONE = 3;

  typedef struct {
    int kind;
    int addr;
    int data;
    int beat;
  } ev_t;

  ev_t  exp_q[$];
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic mr_at_edge = 1'b0;
  int   hs_cyc = 0;
  int   last_wr_cyc = 0;
  int   last_done_cyc = 0;
  int   wdata[8];
  int   mon_n;
  int   mon_kind;
  ev_t  mon_e;

  slave_rx_port_p_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) bus ();

  slave_rx_port_p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    mr_at_edge <= bus.master_ready;
  end

  // Random read back-pressure, ready three quarters of the time.
  always @(negedge clk) bus.master_ready = ($urandom_range(0, 3) != 0);

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon_n = int'(bus.wr_req) + int'(bus.rd_req) + int'(bus.err) + int'(bus.rx_done);
      if (mon_n > 1) begin
        check("one_strobe_at_a_time", mon_n, 1);
      end else if (mon_n == 1) begin
        mon_kind = bus.wr_req ? EV_WR : bus.rd_req ? EV_RD : bus.err ? EV_ERR : EV_DONE;
        if (exp_q.size() == 0) begin
          check("unexpected_event", mon_kind, -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_kind", mon_kind, mon_e.kind);
          if (mon_kind == mon_e.kind) begin
            if (mon_kind == EV_WR || mon_kind == EV_RD) check("addr_out", int'(bus.addr_out), mon_e.addr);
            if (mon_kind == EV_WR) check("data_out", int'(bus.data_out), mon_e.data);
            if (mon_e.beat >= 0) check("beat_count", int'(bus.beat_count), mon_e.beat);
            if (mon_kind == EV_RD && mon_e.beat > 0) check("rd_req_only_when_ready", int'(mr_at_edge), 1);
          end
        end
        if (mon_kind == EV_WR)   last_wr_cyc = cyc;
        if (mon_kind == EV_DONE) last_done_cyc = cyc;
      end
    end
  end

  function automatic bit even_par(input int v, input int w);
    bit p = 1'b0;
    for (int j = 0; j < w; j++) p ^= v[j];
    return p;
  endfunction

  function automatic bit word_bit(input int v, input int w, input int i, input bit bad);
    if (i < w) return v[i];
    if (i == w) return even_par(v, w) ^ bad;
    return 1'($urandom);
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.slave_ready) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    check("slave_ready_timeout", 0, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_slave_ready"}, int'(bus.slave_ready), 0);
    check({tag, "_addr_out"},    int'(bus.addr_out),    0);
    check({tag, "_data_out"},    int'(bus.data_out),    0);
    check({tag, "_wr_req"},      int'(bus.wr_req),      0);
    check({tag, "_rd_req"},      int'(bus.rd_req),      0);
    check({tag, "_beat_count"},  int'(bus.beat_count),  0);
    check({tag, "_rx_done"},     int'(bus.rx_done),     0);
    check({tag, "_err"},         int'(bus.err),         0);
  endtask

  task automatic do_abort();
    #2 reset = 1'b1;
    #1 check_outputs_zero("abort");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Expected behaviour: beat k goes to (addr+k) mod 2^AW carrying word k; a bad parity beat becomes err.
  task automatic send_txn(input bit wr, input int addr, input int blen, input int bad_beat, input int abort_beat);
    bit  ok;
    int  nrx;
    ev_t e;
    for (int k = 0; k <= blen; k++) begin
      e.kind = (PAR != 0 && k == bad_beat) ? EV_ERR : (wr ? EV_WR : EV_RD);
      e.addr = (addr + k) % (1 << AW);
      e.data = wdata[k];
      e.beat = k;
      exp_q.push_back(e);
    end
    e.kind = EV_DONE;
    e.beat = blen;
    exp_q.push_back(e);

    wait_ready(ok);
    if (!ok) return;
    bus.master_valid = 1'b1;
    bus.write_en     = wr;
    bus.read_en      = !wr;
    bus.burst_len    = BW'(blen);
    @(negedge clk);
    hs_cyc           = cyc;
    bus.master_valid = 1'b0;
    bus.write_en     = 1'($urandom);
    bus.read_en      = 1'($urandom);
    bus.burst_len    = BW'($urandom);

    nrx = (wr ? MAXW : AW) + PAR;
    for (int i = 0; i < nrx; i++) begin
      bus.rx_addr = word_bit(addr, AW, i, bad_beat == 0);
      bus.rx_data = wr ? word_bit(wdata[0], DW, i, 1'b0) : 1'($urandom);
      @(negedge clk);
    end

    if (wr) begin
      for (int k = 1; k <= blen; k++) begin
        wait_ready(ok);
        if (!ok) return;
        bus.master_valid = 1'b1;
        @(negedge clk);
        bus.master_valid = 1'b0;
        for (int i = 0; i < DW + PAR; i++) begin
          if (k == abort_beat && i == 3) begin
            do_abort();
            return;
          end
          bus.rx_data = word_bit(wdata[k], DW, i, k == bad_beat);
          bus.rx_addr = 1'($urandom);
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bus.rx_addr      = 1'b0;
    bus.rx_data      = 1'b0;
    bus.master_valid = 1'b0;
    bus.write_en     = 1'b0;
    bus.read_en      = 1'b0;
    bus.burst_len    = '0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    #1 check("ready_low_until_edge", int'(bus.slave_ready), 0);
    @(negedge clk);
    check("ready_after_reset", int'(bus.slave_ready), 1);

    // Single write: latency and done spacing.
    wdata[0] = 'h3E;
    send_txn(1'b1, 'hA5C, 0, -1, -1);
    wait_ready(ok);
    @(negedge clk);
    check("wr_latency", last_wr_cyc - hs_cyc, MAXW + PAR + 1);
    check("done_after_wr", last_done_cyc - last_wr_cyc, 1);
    check("ready_after_done", int'(bus.slave_ready), 1);

    // Write burst with per-beat handshakes.
    wdata[0] = 'h11; wdata[1] = 'h22; wdata[2] = 'h33; wdata[3] = 'h44;
    send_txn(1'b1, 'h010, 3, -1, -1);

    // Read burst wrapping through the top of the address space.
    send_txn(1'b0, 'hFFE, 4, -1, -1);

    // Both modes at once: err pulse, nothing else, IDLE held.
    wait_ready(ok);
    mon_e.kind = EV_ERR; mon_e.addr = 0; mon_e.data = 0; mon_e.beat = -1;
    exp_q.push_back(mon_e);
    bus.master_valid = 1'b1;
    bus.write_en     = 1'b1;
    bus.read_en      = 1'b1;
    @(negedge clk);
    bus.master_valid = 1'b0;
    bus.write_en     = 1'b0;
    bus.read_en      = 1'b0;
    check("illegal_ready_held", int'(bus.slave_ready), 1);
    repeat (3) @(negedge clk);
    check("illegal_err_seen", exp_q.size(), 0);

    // Reset during beat 2 of a write burst, then a clean transaction.
    for (int k = 0; k < 4; k++) wdata[k] = $urandom_range(0, (1 << DW) - 1);
    send_txn(1'b1, 'h200, 3, -1, 2);
    wdata[0] = 'h5A; wdata[1] = 'hC3;
    send_txn(1'b1, 'h100, 1, -1, -1);

    if (PAR != 0) begin
      send_txn(1'b0, 'h3C7, 0, 0, -1);
      wdata[0] = 'h81; wdata[1] = 'h7E; wdata[2] = 'h00;
      send_txn(1'b1, 'hFFF, 2, 1, -1);
    end

    for (int t = 0; t < 14; t++) begin
      int blen;
      int bad;
      blen = $urandom_range(0, 4);
      for (int k = 0; k <= blen; k++) wdata[k] = $urandom_range(0, (1 << DW) - 1);
      bad = (PAR != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, blen) : -1;
      send_txn(1'($urandom), $urandom_range(0, (1 << AW) - 1), blen, bad, -1);
    end

    wait_ready(ok);
    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slave_rx_port_p.md
# slave_rx_port_p

Parametrised serial receive port for system-bus slaves. It deserialises LSB-first address and write-data bit streams after a `master_valid`/`slave_ready` handshake and issues one-cycle memory requests. It supports incrementing write and read bursts of configurable length and sits between the bus interconnect and the slave memory controller. It is the generalised successor of the fixed 8-bit data / 12-bit address slave input port.

## Interface
- `DATA_WIDTH`, default 8: serial data word width (≥2).
- `ADDR_WIDTH`, default 12: serial address width (≥2).
- `BURST_WIDTH`, default 12: width of `burst_len` and `beat_count`.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `rx_addr` in 1: serial address bit, LSB first.
- `rx_data` in 1: serial write-data bit, LSB first.
- `master_valid` in 1: master request valid.
- `master_ready` in 1: master can accept the next read beat.
- `write_en` in 1: write mode, sampled at handshake.
- `read_en` in 1: read mode, sampled at handshake.
- `burst_len` in BURST_WIDTH: beats minus 1 (0 = single beat), sampled at first handshake.
- `slave_ready` out 1: port can accept a handshake (registered).
- `addr_out` out ADDR_WIDTH: request address.
- `data_out` out DATA_WIDTH: write data.
- `wr_req` out 1: one-cycle write strobe.
- `rd_req` out 1: one-cycle read strobe.
- `beat_count` out BURST_WIDTH: index of the current beat.
- `rx_done` out 1: one-cycle pulse when the transaction completes.
- `err` out 1: one-cycle error pulse.

## Operation
- **Handshake** = `master_valid & slave_ready`. `slave_ready` is 1 only in IDLE and WR_WAIT.
- **States:** IDLE, RX, ISSUE, WR_WAIT, WR_DATA, RD_BURST, DONE.
- **IDLE**
  - Handshake with exactly one of `write_en`/`read_en` set: latch mode and `burst_len`, clear `beat_count`, go to RX.
  - Handshake with both set: `err` pulse, stay in IDLE.
  - Handshake with neither set: ignored.
- **RX**
  - Shifts `rx_addr` into bits 0..ADDR_WIDTH-1 of `addr_out`.
  - For writes, shifts `rx_data` into bits 0..DATA_WIDTH-1 of `data_out` in parallel.
  - Length: ADDR_WIDTH cycles for reads, max(ADDR_WIDTH, DATA_WIDTH) cycles for writes.
- **ISSUE:** pulse `wr_req` or `rd_req` for one cycle.
  - If `beat_count == burst_len`: go to DONE.
  - Otherwise, write: go to WR_WAIT; read: go to RD_BURST.
- **WR_WAIT:** on handshake, `addr_out` +1, `beat_count` +1, go to WR_DATA. `write_en`/`read_en` are not re-sampled.
- **WR_DATA:** shift DATA_WIDTH bits of `rx_data`, then go to ISSUE.
- **RD_BURST:** each cycle `master_ready` is 1:
  - `addr_out` +1, `beat_count` +1, `rd_req` pulses with the new address.
  - After the beat where `beat_count` reaches `burst_len`, go to DONE.
  - `master_ready` = 0 stalls with no change.
- **DONE:** `rx_done` pulses one cycle, then go to IDLE.
- **Arithmetic:** `addr_out` increments modulo 2^ADDR_WIDTH (0xFFF → 0x000). `beat_count` never exceeds `burst_len`.
- **Mid-transaction changes:** `burst_len`, `write_en` and `read_en` changes are ignored after the first handshake.

## Timing
- **Reset values:** all outputs 0; state IDLE. `slave_ready` rises on the first clock edge after reset deasserts.
- **Asynchronous reset mid-transaction:** aborts immediately; no request is issued.
- **Handshake sampled at edge T:**
  - First serial bits are sampled at edge T+1.
  - Last bit is sampled at edge T+N, where N is the RX length.
  - Request is visible in the cycle after edge T+N+1.
- **Single write, 8/12 widths:** handshake to `wr_req` is 13 cycles; `rx_done` follows 1 cycle later.
- **Read burst:** consecutive `rd_req` pulses occur every cycle while `master_ready` = 1.
- **`slave_ready`:** registered, so it drops on the edge after the accepting handshake. A second `master_valid` in that cycle is not accepted.

## Configuration
- **`SLAVE_RX_PARITY_EN` defined:**
  - Each serial word (address, each data word) carries one extra even-parity bit after its MSB, which adds one cycle to RX and WR_DATA.
  - On mismatch, ISSUE pulses `err` instead of `wr_req`/`rd_req`. The beat still counts and the burst continues.
- **Not defined:** no parity cycle; `err` asserts only for simultaneous `write_en`/`read_en`.

## Test plan
- **Single write:** handshake with `write_en`, `burst_len` = 0, addr 0xA5C, data 0x3E → one `wr_req` with `addr_out` = 0xA5C, `data_out` = 0x3E, then `rx_done`; `slave_ready` back to 1.
- **Write burst:** `burst_len` = 3, addr 0x010, data 0x11/0x22/0x33/0x44 with a handshake per beat → 4 `wr_req` at addresses 0x010–0x013 with matching data; `beat_count` 0..3.
- **Read burst with stalls:** `burst_len` = 4, addr 0xFFE, `master_ready` toggling 1,0,1,1 → `rd_req` at 0xFFE, 0xFFF, 0x000, 0x001, 0x002 (wrap); no `rd_req` while stalled.
- **Illegal mode:** handshake with `write_en` = `read_en` = 1 → `err` pulse, no request, IDLE held.
- **Reset mid-burst:** `reset` asserted at beat 2 of a write burst → all outputs 0 immediately; next transaction at 0x100 completes normally.
- **Parity (macro defined):** address with bad parity bit → `err` pulse, no `rd_req`, `rx_done` still pulses.
